// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the programmable step sequencer.
// Holds the default step program, the entry layout and the sizing constants
// used by prog_sequencer, step_sync_edge and prog_sequencer_if.
package seq_pkg;

  localparam int NCH       = 5;  // PC output channels
  localparam int PCW       = 6;  // PC value width
  localparam int WRW       = 5;  // write-select code width
  localparam int NSTEPS    = 6;  // program entries, 2..64
  localparam int DB_CYCLES = 4;  // stable clocks needed when debounce is built in
  localparam int IDXW      = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  // One program entry: write-select code, per-channel update mask and the
  // PC start value for each channel (pc[c] belongs to channel c).
  typedef struct packed {
    logic [WRW-1:0]          wr;
    logic [NCH-1:0]          mask;
    logic [NCH-1:0][PCW-1:0] pc;
  } seq_entry_t;

  // Default program. Entry 0 updates every channel so a wrap reinitialises
  // all PCs. Concatenations list pc4 first, pc0 last.
  localparam seq_entry_t SEQ_PROG [NSTEPS] = '{
    '{wr: 5'b00000, mask: 5'b11111, pc: {6'd0,  6'd23, 6'd22, 6'd8, 6'd6}},
    '{wr: 5'b00100, mask: 5'b00001, pc: {6'd0,  6'd0,  6'd0,  6'd0, 6'd7}},
    '{wr: 5'b00101, mask: 5'b00000, pc: {6'd0,  6'd0,  6'd0,  6'd0, 6'd0}},
    '{wr: 5'b00101, mask: 5'b00010, pc: {6'd0,  6'd0,  6'd0,  6'd9, 6'd0}},
    '{wr: 5'b00000, mask: 5'b00100, pc: {6'd0,  6'd0,  6'd23, 6'd0, 6'd0}},
    '{wr: 5'b00000, mask: 5'b11000, pc: {6'd24, 6'd24, 6'd0,  6'd0, 6'd0}}
  };

endpackage

// File: rtl/prog_sequencer_if.sv
// Bus between the front panel / consumer side and the step sequencer.
// Handshake: every level change of step_in is one step request. A step is
// taken only in a cycle where ready=1; with ready=0 one request is held
// pending and any further request is dropped and flagged on overrun. upd
// pulses for one cycle whenever writein/pc_out/step_idx take new values.
interface prog_sequencer_if;

  logic                                      step_in;
  logic                                      ready;
  logic                                      loop_en;
  logic [seq_pkg::WRW-1:0]                   writein;
  logic [seq_pkg::NCH-1:0][seq_pkg::PCW-1:0] pc_out;
  logic [seq_pkg::IDXW-1:0]                  step_idx;
  logic                                      upd;
  logic                                      done;
  logic                                      overrun;

  modport master (
    output step_in, ready, loop_en,
    input  writein, pc_out, step_idx, upd, done, overrun
  );

  modport slave (
    input  step_in, ready, loop_en,
    output writein, pc_out, step_idx, upd, done, overrun
  );

endinterface

// File: rtl/prog_sequencer_step_sync_edge.sv
// Switch input conditioning: 2-flop synchroniser, optional debounce and a
// history flop; req is high while the accepted level differs from history.
// Optional debounce is compiled in with PROG_SEQUENCER_DEBOUNCE_EN.
// After reset an arm chain masks req until the history flop has caught up
// with the real switch level, so releasing reset never produces a step.
module step_sync_edge
  import seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  output logic req
);

  logic       sync1, sync2, hist, lvl;
  logic [3:0] arm;

  // Synchroniser, history flop and post-reset arm chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      arm   <= '0;
    end else begin
      sync1 <= step_in;
      sync2 <= sync1;
      hist  <= lvl;
      arm   <= {arm[2:0], 1'b1};
    end
  end

`ifdef PROG_SEQUENCER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] db_cnt;
  logic          db_lvl;

  // Accept a new level only after DB_CYCLES consecutive differing samples;
  // any bounce back to the accepted level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_lvl <= 1'b0;
      db_cnt <= '0;
    end else if (!arm[3]) begin
      db_lvl <= sync2;
      db_cnt <= '0;
    end else if (sync2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
      db_lvl <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign lvl = db_lvl;
`else
  assign lvl = sync2;
`endif

  assign req = arm[3] & (lvl != hist);

endmodule

// File: rtl/prog_sequencer.sv
// Programmable step sequencer: walks SEQ_PROG one entry per switch toggle,
// driving the write-select code and masked per-channel PC start values.
// Adds one pending-step buffer behind a ready handshake, loop/stop modes
// (done while parked on the last entry) and a sticky overrun flag.
// Optional input debounce: define PROG_SEQUENCER_DEBOUNCE_EN.
module prog_sequencer
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  prog_sequencer_if.slave  bus
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NSTEPS - 1);

  logic                    req;
  logic                    pending;
  logic                    park;
  logic                    blocked;
  logic                    adv;
  logic [IDXW-1:0]         idx_nx;
  seq_entry_t              ent_nx;
  logic [NCH-1:0][PCW-1:0] pc_nx;

  step_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .step_in (bus.step_in),
    .req     (req)
  );

  // Next entry selection and masked PC merge.
  always_comb begin
    park    = (bus.step_idx == LAST) & ~bus.loop_en;
    blocked = bus.done | park;
    adv     = (req | pending) & bus.ready & ~blocked;
    if (bus.step_idx == LAST) begin
      idx_nx = '0;
    end else begin
      idx_nx = bus.step_idx + 1'b1;
    end
    ent_nx = SEQ_PROG[idx_nx];
    pc_nx  = bus.pc_out;
    for (int c = 0; c < NCH; c++) begin
      if (ent_nx.mask[c]) begin
        pc_nx[c] = ent_nx.pc[c];
      end
    end
  end

  // Registered outputs, pending buffer and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.step_idx <= '0;
      bus.writein  <= SEQ_PROG[0].wr;
      bus.pc_out   <= SEQ_PROG[0].pc;
      bus.upd      <= 1'b0;
      bus.done     <= 1'b0;
      bus.overrun  <= 1'b0;
      pending      <= 1'b0;
    end else begin
      bus.upd  <= adv;
      bus.done <= ((adv ? idx_nx : bus.step_idx) == LAST) & ~bus.loop_en;
      if (adv) begin
        bus.step_idx <= idx_nx;
        bus.writein  <= ent_nx.wr;
        bus.pc_out   <= pc_nx;
      end
      // Requests while parked are discarded silently.
      if (blocked) begin
        pending <= 1'b0;
      end else if (adv) begin
        pending <= 1'b0;
        if (req && pending) begin
          bus.overrun <= 1'b1;
        end
      end else if (req) begin
        if (pending) begin
          bus.overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed toggles with hand-computed entry
// outputs pushed to an expected queue; a negedge monitor pops one entry per
// upd pulse. Direct checks cover reset, latency, done/overrun and pending.
module tb_prog_sequencer;
  import seq_pkg::*;

  localparam int W   = IDXW + WRW + NCH * PCW;
`ifdef PROG_SEQUENCER_DEBOUNCE_EN
  localparam int LAT = 3 + DB_CYCLES;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 6;

  // Cumulative outputs after reaching each index from reset or a wrap,
  // pc packed as {pc4,pc3,pc2,pc1,pc0}.
  logic [WRW-1:0]     exp_wr [NSTEPS] = '{5'd0, 5'd4, 5'd5, 5'd5, 5'd0, 5'd0};
  logic [NCH*PCW-1:0] exp_pc [NSTEPS] = '{
    {6'd0,  6'd23, 6'd22, 6'd8, 6'd6},
    {6'd0,  6'd23, 6'd22, 6'd8, 6'd7},
    {6'd0,  6'd23, 6'd22, 6'd8, 6'd7},
    {6'd0,  6'd23, 6'd22, 6'd9, 6'd7},
    {6'd0,  6'd23, 6'd23, 6'd9, 6'd7},
    {6'd24, 6'd24, 6'd23, 6'd9, 6'd7}
  };

  logic clk;
  logic reset;
  prog_sequencer_if bus();

  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  prog_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i);
    logic [IDXW-1:0] idx;
    idx = i[IDXW-1:0];
    exp_q.push_back({idx, exp_wr[i], exp_pc[i]});
  endtask

  task automatic toggle();
    @(negedge clk);
    bus.step_in = ~bus.step_in;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every upd pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (!reset && bus.upd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd act idx=%0d exp=no update", bus.step_idx);
      end else begin
        exp_v = exp_q.pop_front();
        check("upd_outputs", 64'({bus.step_idx, bus.writein, bus.pc_out}), 64'(exp_v));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus.step_in = 1'b1;
    bus.ready   = 1'b1;
    bus.loop_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idx", 64'(bus.step_idx), 64'd0);
    check("rst_wr", 64'(bus.writein), 64'(exp_wr[0]));
    check("rst_pc", 64'(bus.pc_out), 64'(exp_pc[0]));
    check("rst_flags", 64'({bus.upd, bus.done, bus.overrun}), 64'd0);
    reset = 1'b0;
    cycles(10);
    check("release_idx", 64'(bus.step_idx), 64'd0);

    // First step and its latency.
    push_exp(1);
    toggle();
    repeat (LAT - 1) @(posedge clk);
    #1 check("latency_early", 64'(bus.step_idx), 64'd0);
    @(posedge clk);
    #1 check("latency_edge", 64'(bus.step_idx), 64'd1);
    check("latency_upd", 64'(bus.upd), 64'd1);
    @(posedge clk);
    #1 check("upd_single", 64'(bus.upd), 64'd0);
    cycles(SETTLE);

    // Loop mode through the wrap.
    for (int i = 2; i <= NSTEPS; i++) begin
      push_exp(i % NSTEPS);
      toggle();
      cycles(SETTLE);
    end
    check("wrap_done", 64'(bus.done), 64'd0);

    // Stop mode: park on the last entry.
    bus.loop_en = 1'b0;
    for (int i = 1; i < NSTEPS; i++) begin
      push_exp(i);
      toggle();
      cycles(SETTLE);
    end
    check("stop_done", 64'(bus.done), 64'd1);
    toggle();
    cycles(SETTLE);
    check("stop_idx", 64'(bus.step_idx), 64'(NSTEPS - 1));
    check("stop_overrun", 64'(bus.overrun), 64'd0);
    check("stop_done_held", 64'(bus.done), 64'd1);
    bus.loop_en = 1'b1;
    cycles(2);
    check("loop_clears_done", 64'(bus.done), 64'd0);
    push_exp(0);
    toggle();
    cycles(SETTLE);

    // Pending buffer and overrun.
    bus.ready = 1'b0;
    toggle();
    cycles(SETTLE);
    check("pend_no_step", 64'(bus.step_idx), 64'd0);
    check("pend_no_overrun", 64'(bus.overrun), 64'd0);
    toggle();
    cycles(SETTLE);
    check("overrun_set", 64'(bus.overrun), 64'd1);
    push_exp(1);
    bus.ready = 1'b1;
    cycles(SETTLE);
    check("pend_one_adv", 64'(bus.step_idx), 64'd1);

    // Reset mid-sequence with a pending step.
    push_exp(2);
    toggle();
    cycles(SETTLE);
    push_exp(3);
    toggle();
    cycles(SETTLE);
    check("pre_reset_idx", 64'(bus.step_idx), 64'd3);
    bus.ready = 1'b0;
    toggle();
    cycles(SETTLE);
    reset = 1'b1;
    #1;
    check("midrst_idx", 64'(bus.step_idx), 64'd0);
    check("midrst_wr", 64'(bus.writein), 64'(exp_wr[0]));
    check("midrst_pc", 64'(bus.pc_out), 64'(exp_pc[0]));
    check("midrst_overrun", 64'(bus.overrun), 64'd0);
    cycles(2);
    reset     = 1'b0;
    bus.ready = 1'b1;
    cycles(SETTLE + 4);
    check("midrst_no_pending", 64'(bus.step_idx), 64'd0);
    push_exp(1);
    toggle();
    cycles(SETTLE);
    check("post_rst_step", 64'(bus.step_idx), 64'd1);

`ifdef PROG_SEQUENCER_DEBOUNCE_EN
    // Two-cycle glitch must be rejected.
    toggle();
    @(negedge clk);
    toggle();
    cycles(SETTLE);
    check("glitch_rejected", 64'(bus.step_idx), 64'd1);
`endif

    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
